// File: rtl/mul_add_pkg.sv
// Shared types for the packed mul-add stage-0 tuple interface and its add stage.
package mul_add_pkg;
  localparam int W = 32;

  // partial sits in the high half, matching the stage-0 output layout.
  typedef struct packed {
    logic [W-1:0] partial;
    logic [W-1:0] z;
  } tuple_t;

  typedef struct packed {
    logic         carry;
    logic [W-1:0] sum;
  } sum_t;
endpackage

// File: rtl/mul_add_tuple_skid.sv
// Stage A plus a one-entry skid buffer; in_ready is registered so that no
// combinational path exists from the downstream take signal back to the producer.
module mul_add_tuple_skid #(
  parameter int W = mul_add_pkg::W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*W-1:0] in_data,
  input  logic           b_take,
  output logic           a_valid,
  output logic [2*W-1:0] a_data,
  output logic           a_adv
);
  logic           skid_valid;
  logic [2*W-1:0] skid_data;
  logic           hs;
  logic           a_valid_nxt;
  logic           skid_valid_nxt;
  logic           load_a_skid;
  logic           load_a_in;
  logic           load_skid;

  assign hs    = in_valid && in_ready;
  assign a_adv = a_valid && b_take;

  always_comb begin
    a_valid_nxt    = a_valid;
    skid_valid_nxt = skid_valid;
    load_a_skid    = 1'b0;
    load_a_in      = 1'b0;
    load_skid      = 1'b0;
    if (a_adv && skid_valid) begin
      // in_ready is low whenever the skid is full, so no handshake can collide here.
      load_a_skid    = 1'b1;
      skid_valid_nxt = 1'b0;
    end else if ((a_adv || !a_valid) && hs) begin
      load_a_in   = 1'b1;
      a_valid_nxt = 1'b1;
    end else if (a_adv) begin
      a_valid_nxt = 1'b0;
    end else if (a_valid && hs) begin
      load_skid      = 1'b1;
      skid_valid_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_valid    <= 1'b0;
      skid_valid <= 1'b0;
      in_ready   <= 1'b0;
    end else begin
      a_valid    <= a_valid_nxt;
      skid_valid <= skid_valid_nxt;
      in_ready   <= !skid_valid_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (load_a_skid) a_data <= skid_data;
    else if (load_a_in) a_data <= in_data;
    if (load_skid) skid_data <= in_data;
  end
endmodule

// File: rtl/mul_add_tuple_sink.sv
// Backpressured consumer of {partial, z} tuples: adds the two fields and returns
// sum and carry. Both ports use valid/ready: a transfer happens on any rising edge
// where valid && ready; a producer holds valid and data stable until it transfers.
module mul_add_tuple_sink #(
  parameter int W     = mul_add_pkg::W,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2*W-1:0]   in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic             out_carry,
  output logic [CNT_W-1:0] xfer_count
);
  logic           a_valid;
  logic [2*W-1:0] a_data;
  logic           a_adv;
  logic           b_take;
  logic           b_valid;
  logic [W-1:0]   b_sum;
  logic           b_carry;
  logic [W:0]     add_w;

  assign b_take = !b_valid || out_ready;

  mul_add_tuple_skid #(.W(W)) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .b_take   (b_take),
    .a_valid  (a_valid),
    .a_data   (a_data),
    .a_adv    (a_adv)
  );

  assign add_w = {1'b0, a_data[2*W-1:W]} + {1'b0, a_data[W-1:0]};

  // Sum and carry hold when B empties so a stalled result never changes under the consumer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      b_valid    <= 1'b0;
      b_sum      <= '0;
      b_carry    <= 1'b0;
      xfer_count <= '0;
    end else begin
      if (a_adv) begin
        b_valid <= 1'b1;
        b_sum   <= add_w[W-1:0];
        b_carry <= add_w[W];
      end else if (out_ready && b_valid) begin
        b_valid <= 1'b0;
      end
      if (in_valid && in_ready) xfer_count <= xfer_count + CNT_W'(1);
    end
  end

  assign out_valid = b_valid;
  assign out_data  = b_sum;
  assign out_carry = b_carry;
endmodule

// File: tb/tb_mul_add_tuple_sink.sv
// Bench for mul_add_tuple_sink: directed literal cases plus randomized traffic
// against a queue-based model of the sink's contents.
module tb_mul_add_tuple_sink;
  import mul_add_pkg::*;
  localparam int CNT_W = 32;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [2*W-1:0]   in_data;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_data;
  logic             out_carry;
  logic [CNT_W-1:0] xfer_count;

  mul_add_tuple_sink #(.W(W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_carry  (out_carry),
    .xfer_count (xfer_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard state
  int               checks = 0;
  int               errors = 0;
  logic [W:0]       exp_q[$];
  int               n_out = 0;
  logic [CNT_W-1:0] exp_xfer = '0;
  logic             exp_in_ready = 1'b0;
  bit               model_ok = 0;
  logic             prev_rst_n = 1'b0;
  logic             prev_ov = 1'b0;
  logic             prev_or = 1'b0;
  logic [W-1:0]     prev_data = '0;
  logic             prev_carry = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [W:0] ref_sum(input tuple_t t);
    return {1'b0, t.partial} + {1'b0, t.z};
  endfunction

  function automatic tuple_t mk(input logic [W-1:0] p, input logic [W-1:0] z);
    tuple_t t;
    t.partial = p;
    t.z       = z;
    return t;
  endfunction

  // The sink holds at most 3 tuples; it is ready whenever fewer than 3 remain after an edge.
  always @(negedge clk) begin
    if (model_ok) begin
      chk("in_ready", in_ready, exp_in_ready);
      chk("xfer_count", xfer_count, exp_xfer);
      if (prev_rst_n && prev_ov && !prev_or) begin
        chk("stall_valid", out_valid, 1'b1);
        chk("stall_data", {out_carry, out_data}, {prev_carry, prev_data});
      end
      if (out_valid) begin
        chk("out_without_pending", exp_q.size() != 0, 1'b1);
        if (out_ready && exp_q.size() != 0) begin
          chk("result_order", {out_carry, out_data}, exp_q.pop_front());
          n_out++;
        end
      end
    end
    if (!rst_n) begin
      exp_q.delete();
      exp_xfer     = '0;
      exp_in_ready = 1'b0;
      model_ok     = 1;
    end else if (model_ok) begin
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_sum(tuple_t'(in_data)));
        exp_xfer = exp_xfer + 1;
      end
      exp_in_ready = (exp_q.size() < 3);
    end
    prev_rst_n = rst_n;
    prev_ov    = out_valid;
    prev_or    = out_ready;
    prev_data  = out_data;
    prev_carry = out_carry;
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input tuple_t t);
    int n;
    bit got;
    in_valid = 1'b1;
    in_data  = t;
    n = 0;
    got = 0;
    while (!got && n < 1000) begin
      @(negedge clk);
      got = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got no handshake in %0d cycles, expected one", n);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    int c0;
    int n0;
    int sent;
    int guard;
    bit got;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    repeat (2) tick();
    chk("reset_in_ready", in_ready, 1'b0);
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_data", {out_carry, out_data}, '0);
    rst_n = 1'b1;
    tick();
    chk("ready_after_reset", in_ready, 1'b1);
    chk("xfer_after_reset", xfer_count, 0);

    // single tuple: visible two cycles after the cycle it was presented
    send(mk(32'h5, 32'h7));
    chk("single_not_yet", out_valid, 1'b0);
    tick();
    chk("single_valid", out_valid, 1'b1);
    chk("single_data", out_data, 32'h0000000C);
    chk("single_carry", out_carry, 1'b0);
    chk("single_xfer", xfer_count, 1);

    send(mk(32'hFFFFFFFF, 32'h2));
    tick();
    chk("carry_data", out_data, 32'h00000001);
    chk("carry_carry", out_carry, 1'b1);
    repeat (3) tick();

    // backpressure fill: exactly three accepted
    out_ready = 1'b0;
    send(mk(1, 1));
    send(mk(2, 2));
    send(mk(3, 3));
    chk("fill_ready_drop", in_ready, 1'b0);
    in_valid = 1'b1;
    in_data  = mk(4, 4);
    repeat (3) begin
      tick();
      chk("fill_ready_low", in_ready, 1'b0);
    end
    chk("fill_head", out_data, 2);
    out_ready = 1'b1;
    tick();
    chk("drain_1", out_data, 4);
    chk("drain_ready_back", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    chk("drain_2", out_data, 6);
    tick();
    chk("drain_3", out_data, 8);
    repeat (3) tick();

    // streaming 100 back-to-back tuples
    do_reset();
    tick();
    n0 = n_out;
    c0 = cyc;
    for (int i = 0; i < 100; i++) begin
      send(mk($urandom, $urandom));
      if (i == 0) chk("stream_first_latency", out_valid, 1'b0);
      if (i == 1) chk("stream_first_out", out_valid, 1'b1);
    end
    chk("stream_cycles", cyc - c0, 100);
    tick();
    tick();
    @(negedge clk);
    chk("stream_count", n_out - n0, 100);
    chk("stream_xfer", xfer_count, 100);
    tick();

    // random valid (70%) and ready (50%)
    sent  = 0;
    guard = 0;
    while (sent < 10000 && guard < 90000) begin
      if (!in_valid && $urandom_range(99) < 70) begin
        in_valid = 1'b1;
        in_data  = {$urandom, $urandom};
      end
      out_ready = $urandom_range(1);
      @(negedge clk);
      got = in_valid && in_ready;
      @(posedge clk);
      #1;
      guard++;
      if (got) begin
        sent++;
        in_valid = 1'b0;
      end
    end
    chk("random_all_sent", sent, 10000);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (5) tick();
    chk("random_drained", exp_q.size(), 0);

    // reset with 3 tuples in flight
    out_ready = 1'b0;
    send(mk(100, 1));
    send(mk(200, 2));
    send(mk(300, 3));
    rst_n = 1'b0;
    tick();
    chk("mid_reset_out_valid", out_valid, 1'b0);
    chk("mid_reset_xfer", xfer_count, 0);
    chk("mid_reset_in_ready", in_ready, 1'b0);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    tick();
    chk("mid_reset_ready_back", in_ready, 1'b1);
    repeat (5) tick();
    chk("flushed_none", out_valid, 1'b0);
    send(mk(10, 20));
    tick();
    chk("post_reset_data", out_data, 30);
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
